// File: rtl/wu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : wu_fetch
// Brief    : Work-unit instruction fetch; issues sequential, stall-throttled
//            reads into WU instruction memory and signals done after drain.
// Revision : 1.0 - initial release
// ============================================================================
module wu_fetch #(
    parameter int WUF_ADDR_WIDTH   = 10,
    parameter int WUF_MEM_DEPTH    = 1024,
    parameter int WUF_COUNT_WIDTH  = 11,
    parameter int WUF_DRAIN_CYCLES = 3,
    parameter int MGR_ID_WIDTH     = 8
) (
    input  logic                       clk,
    input  logic                       reset_poweron,
    input  logic [MGR_ID_WIDTH-1:0]    sys__mgr__mgrId,
    input  logic                       cntl__wuf__start,
    input  logic [WUF_ADDR_WIDTH-1:0]  cntl__wuf__start_addr,
    input  logic [WUF_COUNT_WIDTH-1:0] cntl__wuf__num_inst,
    input  logic                       cntl__wuf__abort,
    output logic                       wuf__cntl__busy,
    output logic                       wuf__cntl__done,
    output logic [WUF_ADDR_WIDTH-1:0]  wuf__wum__addr,
    output logic                       wuf__wum__read,
    input  logic                       wum__wuf__stall
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int c_DRAIN_W = (WUF_DRAIN_CYCLES > 1) ? $clog2(WUF_DRAIN_CYCLES) : 1;
    localparam logic [WUF_ADDR_WIDTH-1:0]  c_LAST_ADDR  = WUF_ADDR_WIDTH'(WUF_MEM_DEPTH - 1);
    localparam logic [c_DRAIN_W-1:0]       c_DRAIN_INIT =
        c_DRAIN_W'((WUF_DRAIN_CYCLES > 1) ? (WUF_DRAIN_CYCLES - 1) : 0);
    localparam logic [WUF_COUNT_WIDTH-1:0] c_CNT_ONE    = WUF_COUNT_WIDTH'(1);

    logic [1:0]                 r_state;
    logic [WUF_ADDR_WIDTH-1:0]  r_cur_addr;
    logic [WUF_COUNT_WIDTH-1:0] r_remaining;
    logic [c_DRAIN_W-1:0]       r_drain_cnt;
    logic                       w_read;
    logic                       w_unused;

    // Manager id is carried for debug visibility only.
    assign w_unused = ^sys__mgr__mgrId;

    assign w_read          = (r_state == S_FETCH) && !wum__wuf__stall;
    assign wuf__wum__read  = w_read;
    assign wuf__wum__addr  = (r_state == S_FETCH) ? r_cur_addr : '0;
    assign wuf__cntl__busy = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign wuf__cntl__done = (r_state == S_DONE);

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            r_state     <= S_IDLE;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_drain_cnt <= '0;
        end else if (cntl__wuf__abort) begin
            r_state     <= S_IDLE;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cntl__wuf__start) begin
                        r_cur_addr  <= cntl__wuf__start_addr;
                        r_remaining <= cntl__wuf__num_inst;
                        r_state     <= (cntl__wuf__num_inst != '0) ? S_FETCH : S_DONE;
                    end
                end
                S_FETCH: begin
                    if (w_read) begin
                        r_cur_addr <= (r_cur_addr == c_LAST_ADDR) ? '0
                                      : r_cur_addr + WUF_ADDR_WIDTH'(1);
                        if (r_remaining != '0) begin
                            r_remaining <= r_remaining - c_CNT_ONE;
                        end
                        if (r_remaining == c_CNT_ONE) begin
                            r_drain_cnt <= c_DRAIN_INIT;
                            r_state     <= (WUF_DRAIN_CYCLES > 1) ? S_DRAIN : S_DONE;
                        end
                    end
                end
                S_DRAIN: begin
                    // Leaving on count 1 puts DONE exactly DRAIN_CYCLES after the last read.
                    if (r_drain_cnt <= c_DRAIN_W'(1)) begin
                        r_drain_cnt <= '0;
                        r_state     <= S_DONE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - c_DRAIN_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_wu_fetch
// Brief    : Scoreboard bench for wu_fetch; expected read addresses and done
//            timing come from a run-level model of start address and count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wu_fetch;

    localparam int c_DEPTH = 1024;
    localparam int c_DRAIN = 3;
    localparam int c_GUARD = 4000;

    logic        clk = 1'b0;
    logic        reset_poweron = 1'b1;
    logic [7:0]  mgr_id = 8'h5a;
    logic        start = 1'b0;
    logic [9:0]  start_addr = '0;
    logic [10:0] num_inst = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic [9:0]  addr;
    logic        read;
    logic        stall = 1'b1;

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int exp_done = -1;
    int reads_seen = 0;
    int q[$];
    bit exp_busy;

    wu_fetch dut (
        .clk                   (clk),
        .reset_poweron         (reset_poweron),
        .sys__mgr__mgrId       (mgr_id),
        .cntl__wuf__start      (start),
        .cntl__wuf__start_addr (start_addr),
        .cntl__wuf__num_inst   (num_inst),
        .cntl__wuf__abort      (abort),
        .wuf__cntl__busy       (busy),
        .wuf__cntl__done       (done),
        .wuf__wum__addr        (addr),
        .wuf__wum__read        (read),
        .wum__wuf__stall       (stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: compares every cycle against the run-level expectation.
    always @(negedge clk) begin
        if (!reset_poweron) begin
            exp_busy = (q.size() != 0) || (exp_done >= 0 && cycle < exp_done);
            check("busy", int'(busy), int'(exp_busy));
            if (q.size() != 0) begin
                check("read", int'(read), int'(!stall));
                check("addr", int'(addr), q[0]);
                if (read) begin
                    void'(q.pop_front());
                    reads_seen++;
                    if (q.size() == 0) exp_done = cycle + c_DRAIN;
                end
            end else begin
                check("read_idle", int'(read), 0);
                check("addr_idle", int'(addr), 0);
            end
            if (exp_done >= 0 && cycle == exp_done) begin
                check("done", int'(done), 1);
                exp_done = -1;
            end else begin
                check("done_low", int'(done), 0);
            end
        end
    end

    // mode: 0 no stall, 1 random stall + stray starts, 2 two-cycle stall after 2nd read
    task automatic run(input int a, input int n, input int mode,
                       input int abort_after, input int reset_after);
        int guard;
        int stall_hold;
        reads_seen = 0;
        stall_hold = 0;
        start      = 1'b1;
        start_addr = 10'(a);
        num_inst   = 11'(n);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) q.push_back((a + i) % c_DEPTH);
        if (n == 0) exp_done = cycle;
        guard = 0;
        while ((q.size() != 0 || exp_done >= 0) && guard < c_GUARD) begin
            case (mode)
                0: stall = 1'b0;
                1: stall = ($urandom_range(0, 3) == 0);
                default: begin
                    if (reads_seen >= 2 && stall_hold < 2) begin
                        stall = 1'b1;
                        stall_hold++;
                    end else begin
                        stall = 1'b0;
                    end
                end
            endcase
            if (abort_after >= 0 && reads_seen >= abort_after) begin
                stall = 1'b0;
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                q.delete();
                exp_done = -1;
                break;
            end
            if (reset_after >= 0 && reads_seen >= reset_after) begin
                stall = 1'b0;
                #1 reset_poweron = 1'b1;
                #1;
                check("rst_read", int'(read), 0);
                check("rst_addr", int'(addr), 0);
                check("rst_busy", int'(busy), 0);
                q.delete();
                exp_done = -1;
                @(posedge clk); #1;
                reset_poweron = 1'b0;
                break;
            end
            if (mode == 1 && q.size() != 0 && $urandom_range(0, 5) == 0) begin
                start      = 1'b1;
                start_addr = 10'($urandom);
                num_inst   = 11'($urandom_range(1, 8));
            end
            @(posedge clk); #1;
            start = 1'b0;
            guard++;
        end
        tests++;
        if (guard >= c_GUARD) begin
            fails++;
            $display("FAIL timeout: run addr=%0d num=%0d still pending after %0d cycles", a, n, guard);
            q.delete();
            exp_done = -1;
        end
        stall = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        #3;
        check("reset_busy", int'(busy), 0);
        check("reset_read", int'(read), 0);
        check("reset_addr", int'(addr), 0);
        check("reset_done", int'(done), 0);
        repeat (2) @(posedge clk);
        #1 reset_poweron = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        run(5, 4, 0, -1, -1);
        run(0, 6, 2, -1, -1);
        run(1022, 4, 0, -1, -1);
        run(7, 0, 0, -1, -1);
        run(40, 10, 0, 3, -1);
        run(20, 1, 0, -1, -1);
        run(100, 20, 0, -1, 5);

        // start and abort together in IDLE: abort wins
        start = 1'b1; abort = 1'b1; start_addr = 10'd9; num_inst = 11'd3;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        run(1000, 1030, 1, -1, -1);
        for (int r = 0; r < 25; r++) begin
            int ab;
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 6)) : -1;
            run(int'($urandom_range(0, c_DEPTH - 1)), int'($urandom_range(0, 40)), 1, ab, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
